// File: rtl/ex_muldiv_unit.sv
// EX-stage ALU control decode plus an iterative mult/div unit that owns HI/LO.
// Decode is combinational; long ops take WIDTH+1 cycles (1 on divide-by-zero) and hold Stall_EX until the result commits.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       ALUOp_EX,
  input  logic [5:0]       Funct_EX,
  input  logic             Valid_EX,
  input  logic             Flush_EX,
  input  logic [WIDTH-1:0] OperandA_EX,
  input  logic [WIDTH-1:0] OperandB_EX,
  output logic [3:0]       ALU_Control_EX,
  output logic             Stall_EX,
  output logic [WIDTH-1:0] Hi_EX,
  output logic [WIDTH-1:0] Lo_EX,
  output logic             Done_EX,
  output logic             DivZero_EX
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div, q_neg, r_neg, dz;

  logic             is_r, is_mf, long_op, op_div, op_signed, start, div_zero, commit;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_r      = (ALUOp_EX == 2'b10);
  assign long_op   = is_r && (Funct_EX[5:2] == 4'b0110);
  assign is_mf     = is_r && ((Funct_EX == 6'b010000) || (Funct_EX == 6'b010010));
  assign op_div    = Funct_EX[1];
  assign op_signed = !Funct_EX[0];
  assign start     = (state == IDLE) && Valid_EX && !Flush_EX && long_op;
  assign div_zero  = op_div && (OperandB_EX == '0);

  // Signed ops iterate on magnitudes; signs are reapplied when the result is read out.
  assign a_neg = op_signed && OperandA_EX[WIDTH-1];
  assign b_neg = op_signed && OperandB_EX[WIDTH-1];
  assign a_mag = a_neg ? -OperandA_EX : OperandA_EX;
  assign b_mag = b_neg ? -OperandB_EX : OperandB_EX;

  always_comb begin
    ALU_Control_EX = 4'b0011;
    case (ALUOp_EX)
      2'b00: ALU_Control_EX = 4'b0010;
      2'b01: ALU_Control_EX = 4'b0110;
      2'b10: begin
        case (Funct_EX)
          6'b100000: ALU_Control_EX = 4'b0010;
          6'b100010: ALU_Control_EX = 4'b0110;
          6'b100100: ALU_Control_EX = 4'b0000;
          6'b100101: ALU_Control_EX = 4'b0001;
          6'b101010: ALU_Control_EX = 4'b0111;
          6'b100001: ALU_Control_EX = 4'b1111;
          6'b010000: ALU_Control_EX = 4'b1000;
          6'b010010: ALU_Control_EX = 4'b1001;
          default:   ALU_Control_EX = 4'b0011;
        endcase
      end
      default: ALU_Control_EX = 4'b0011;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = div_zero ? DONE : BUSY;
      BUSY: begin
        if (Flush_EX)                          state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush in DONE suppresses the commit, so Done/DivZero and the HI/LO forward are all gated by it.
  assign commit     = (state == DONE) && !Flush_EX;
  assign Done_EX    = commit;
  assign DivZero_EX = commit && dz;
  assign Stall_EX   = start || (state == BUSY) || (is_mf && Valid_EX && (state == BUSY));

  logic [WIDTH:0]       add_sum, shifted, rem_nxt;
  logic                 sub_ok;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
  assign sub_ok   = (shifted >= {1'b0, opnd});
  assign rem_nxt  = sub_ok ? (shifted - {1'b0, opnd}) : shifted;

  assign prod_fix = q_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign res_lo   = is_div ? (q_neg ? -acc_lo : acc_lo) : prod_fix[WIDTH-1:0];
  assign res_hi   = is_div ? (r_neg ? -acc_hi : acc_hi) : prod_fix[2*WIDTH-1:WIDTH];

  // The committing value is forwarded in DONE so an mfhi/mflo released by the stall sees it.
  assign Hi_EX = commit ? res_hi : hi_q;
  assign Lo_EX = commit ? res_lo : lo_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt    <= '0;
        is_div <= op_div;
        dz     <= div_zero;
        if (div_zero) begin
          acc_hi <= OperandA_EX;
          acc_lo <= '1;
          opnd   <= OperandB_EX;
          q_neg  <= 1'b0;
          r_neg  <= 1'b0;
        end else begin
          acc_hi <= '0;
          acc_lo <= op_div ? a_mag : b_mag;
          opnd   <= op_div ? b_mag : a_mag;
          q_neg  <= a_neg ^ b_neg;
          r_neg  <= a_neg;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          acc_hi <= WIDTH'(rem_nxt);
          acc_lo <= {acc_lo[WIDTH-2:0], sub_ok};
        end else begin
          acc_hi <= add_sum[WIDTH:1];
          acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
        end
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: decode tables, directed long-op vectors, flush/reset corners, random ops vs a model.
module tb_ex_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  ALUOp_EX;
  logic [5:0]  Funct_EX;
  logic        Valid_EX;
  logic        Flush_EX;
  logic [31:0] OperandA_EX, OperandB_EX;
  logic [3:0]  ALU_Control_EX;
  logic        Stall_EX;
  logic [31:0] Hi_EX, Lo_EX;
  logic        Done_EX, DivZero_EX;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .ALUOp_EX(ALUOp_EX), .Funct_EX(Funct_EX),
    .Valid_EX(Valid_EX), .Flush_EX(Flush_EX), .OperandA_EX(OperandA_EX),
    .OperandB_EX(OperandB_EX), .ALU_Control_EX(ALU_Control_EX), .Stall_EX(Stall_EX),
    .Hi_EX(Hi_EX), .Lo_EX(Lo_EX), .Done_EX(Done_EX), .DivZero_EX(DivZero_EX)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [1:0] op; logic [5:0] f; logic [3:0] code; } dec_vec_t;
  dec_vec_t dv[15];

  typedef struct { logic [5:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo; logic dz; int lat; } op_vec_t;
  op_vec_t ov[5];

  function automatic logic [3:0] exp_code(input logic [1:0] op, input logic [5:0] f);
    for (int i = 0; i < 15; i++)
      if (dv[i].op == op && (op != 2'b10 || dv[i].f == f)) return dv[i].code;
    return 4'b0011;
  endfunction

  // Reference: returns {divzero, hi, lo} using plain wide arithmetic.
  function automatic logic [64:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p = '0;
    case (f[1:0])
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'b0) return {1'b1, a, 32'hFFFFFFFF};
        if (f[0]) p = {a % b, a / b};
        else begin
          p[31:0]  = 32'(sa / sb);
          p[63:32] = 32'(sa % sb);
        end
      end
    endcase
    return {1'b0, p};
  endfunction

  // Called at posedge+1: presents the op, holds it while stalled, and returns at posedge+1 after release.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output int done_at, output logic [31:0] hi,
                       output logic [31:0] lo, output logic dz);
    ALUOp_EX = 2'b10; Funct_EX = f; OperandA_EX = a; OperandB_EX = b; Valid_EX = 1'b1;
    stalls = 0; done_at = -1; hi = 'x; lo = 'x; dz = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge Clk);
      if (Stall_EX) stalls++;
      if (Done_EX) begin
        done_at = k; hi = Hi_EX; lo = Lo_EX; dz = DivZero_EX;
      end
      if (!Stall_EX) break;
    end
    @(posedge Clk); #1;
    Valid_EX = 1'b0; Funct_EX = 6'b0; ALUOp_EX = 2'b00;
  endtask

  initial begin
    logic [64:0] r;
    int stalls, done_at, dones;
    logic [31:0] hi, lo, a, b, last_hi, last_lo;
    logic [5:0] f;
    logic dz;

    dv[0]  = '{2'b00, 6'b000000, 4'b0010};
    dv[1]  = '{2'b01, 6'b000000, 4'b0110};
    dv[2]  = '{2'b11, 6'b000000, 4'b0011};
    dv[3]  = '{2'b10, 6'b100000, 4'b0010};
    dv[4]  = '{2'b10, 6'b100010, 4'b0110};
    dv[5]  = '{2'b10, 6'b100100, 4'b0000};
    dv[6]  = '{2'b10, 6'b100101, 4'b0001};
    dv[7]  = '{2'b10, 6'b101010, 4'b0111};
    dv[8]  = '{2'b10, 6'b100001, 4'b1111};
    dv[9]  = '{2'b10, 6'b010000, 4'b1000};
    dv[10] = '{2'b10, 6'b010010, 4'b1001};
    dv[11] = '{2'b10, 6'b011000, 4'b0011};
    dv[12] = '{2'b10, 6'b011001, 4'b0011};
    dv[13] = '{2'b10, 6'b011010, 4'b0011};
    dv[14] = '{2'b10, 6'b011011, 4'b0011};

    ov[0] = '{6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    ov[1] = '{6'b011000, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    ov[2] = '{6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    ov[3] = '{6'b011011, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1};
    ov[4] = '{6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};

    Reset = 1'b0; ALUOp_EX = 2'b00; Funct_EX = 6'b0; Valid_EX = 1'b0; Flush_EX = 1'b0;
    OperandA_EX = '0; OperandB_EX = '0;
    #2 Reset = 1'b1;
    #1;
    check("reset_hi", Hi_EX, 0);
    check("reset_lo", Lo_EX, 0);
    check("reset_done", Done_EX, 0);
    check("reset_divzero", DivZero_EX, 0);
    check("reset_stall", Stall_EX, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    last_hi = 0; last_lo = 0;

    for (int i = 0; i < 15; i++) begin
      ALUOp_EX = dv[i].op; Funct_EX = dv[i].f; #1;
      check($sformatf("dec_tab%0d", i), ALU_Control_EX, dv[i].code);
    end
    for (int op = 0; op < 4; op++)
      for (int fi = 0; fi < 64; fi++) begin
        ALUOp_EX = 2'(op); Funct_EX = 6'(fi); #1;
        check($sformatf("dec_sweep_%0d_%0d", op, fi), ALU_Control_EX, exp_code(2'(op), 6'(fi)));
      end
    ALUOp_EX = 2'b00; Funct_EX = 6'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_op(ov[i].f, ov[i].a, ov[i].b, stalls, done_at, hi, lo, dz);
      check($sformatf("vec%0d_latency", i), done_at, ov[i].lat);
      check($sformatf("vec%0d_stalls", i), stalls, ov[i].lat);
      check($sformatf("vec%0d_hi", i), hi, ov[i].hi);
      check($sformatf("vec%0d_lo", i), lo, ov[i].lo);
      check($sformatf("vec%0d_divzero", i), dz, ov[i].dz);
      @(negedge Clk);
      check($sformatf("vec%0d_hold_hi", i), Hi_EX, ov[i].hi);
      check($sformatf("vec%0d_hold_lo", i), Lo_EX, ov[i].lo);
      @(posedge Clk); #1;
    end

    // mflo arriving in EX while the multiply is busy
    a = 32'd123457; b = 32'd98765;
    r = ref_op(6'b011001, a, b);
    ALUOp_EX = 2'b10; Funct_EX = 6'b011001; OperandA_EX = a; OperandB_EX = b; Valid_EX = 1'b1;
    @(negedge Clk);
    check("mflo_start_stall", Stall_EX, 1);
    @(posedge Clk); #1;
    Funct_EX = 6'b010010;
    stalls = 0;
    for (int k = 1; k < 80; k++) begin
      @(negedge Clk);
      if (!Stall_EX) break;
      stalls++;
    end
    check("mflo_busy_stalls", stalls, 32);
    check("mflo_done", Done_EX, 1);
    check("mflo_code", ALU_Control_EX, 4'b1001);
    check("mflo_lo", Lo_EX, r[31:0]);
    check("mflo_hi", Hi_EX, r[63:32]);
    last_hi = r[63:32]; last_lo = r[31:0];
    @(posedge Clk); #1;
    Valid_EX = 1'b0; ALUOp_EX = 2'b00; Funct_EX = 6'b0;

    // flush on BUSY cycle 10
    ALUOp_EX = 2'b10; Funct_EX = 6'b011000; OperandA_EX = 32'd55; OperandB_EX = 32'd77; Valid_EX = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    Flush_EX = 1'b1; Valid_EX = 1'b0;
    @(negedge Clk);
    check("flush_no_done", Done_EX, 0);
    @(posedge Clk); #1;
    Flush_EX = 1'b0; Valid_EX = 1'b1; Funct_EX = 6'b010010;
    @(negedge Clk);
    check("flush_idle_no_stall", Stall_EX, 0);
    check("flush_hi_kept", Hi_EX, last_hi);
    check("flush_lo_kept", Lo_EX, last_lo);
    @(posedge Clk); #1;
    Valid_EX = 1'b0; ALUOp_EX = 2'b00; Funct_EX = 6'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done_EX) dones++;
    end
    check("flush_no_late_done", dones, 0);
    @(posedge Clk); #1;

    // reset in the middle of a second operation
    ALUOp_EX = 2'b10; Funct_EX = 6'b011011; OperandA_EX = 32'd1000; OperandB_EX = 32'd7; Valid_EX = 1'b1;
    repeat (15) @(posedge Clk);
    #1;
    Reset = 1'b1; Valid_EX = 1'b0;
    #1;
    check("midreset_hi", Hi_EX, 0);
    check("midreset_lo", Lo_EX, 0);
    check("midreset_stall", Stall_EX, 0);
    check("midreset_done", Done_EX, 0);
    check("midreset_divzero", DivZero_EX, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done_EX || Stall_EX) dones++;
    end
    check("midreset_quiet_after", dones, 0);
    last_hi = 0; last_lo = 0;

    // start accepted on the first edge after reset release
    @(posedge Clk);
    Reset = 1'b1;
    #1 Reset = 1'b0;
    r = ref_op(6'b011010, 32'hFFFFFC18, 32'd13);
    do_op(6'b011010, 32'hFFFFFC18, 32'd13, stalls, done_at, hi, lo, dz);
    check("post_reset_latency", done_at, 33);
    check("post_reset_hi", hi, r[63:32]);
    check("post_reset_lo", lo, r[31:0]);

    for (int i = 0; i < 60; i++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      r = ref_op(f, a, b);
      do_op(f, a, b, stalls, done_at, hi, lo, dz);
      check($sformatf("rnd%0d_latency", i), done_at, r[64] ? 1 : 33);
      check($sformatf("rnd%0d_hi", i), hi, r[63:32]);
      check($sformatf("rnd%0d_lo", i), lo, r[31:0]);
      check($sformatf("rnd%0d_divzero", i), dz, r[64]);
      @(negedge Clk);
      check($sformatf("rnd%0d_hold_lo", i), Lo_EX, r[31:0]);
      @(posedge Clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
